// File: rtl/div_unit_if.sv
// Launch/result bundle between the execute stage and the divider.
// The divider drives the HiLo write ports (LO = quotient, HI = remainder).
interface div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] wLoData;
    logic             wlo;
    logic [WIDTH-1:0] wHiData;
    logic             whi;

    modport master (
        output start, signed_div, dividend, divisor, cancel,
        input  busy, done, div_zero, wLoData, wlo, wHiData, whi
    );

    modport slave (
        input  start, signed_div, dividend, divisor, cancel,
        output busy, done, div_zero, wLoData, wlo, wHiData, whi
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Iterates on magnitudes, then fixes signs; one quotient bit per CALC cycle.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic             q_neg;
    logic             r_neg;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;

    logic             sgn_a;
    logic             sgn_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic             pulse;

    // |0x80000000| wraps to itself; read as unsigned it is still the right magnitude.
    always_comb begin
        sgn_a  = bus.signed_div & bus.dividend[WIDTH-1];
        sgn_b  = bus.signed_div & bus.divisor[WIDTH-1];
        abs_a  = sgn_a ? -bus.dividend : bus.dividend;
        abs_b  = sgn_b ? -bus.divisor  : bus.divisor;
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dsr};
        // rem_sh < 2*dsr, so the top bit of the difference is exactly the borrow.
        ge     = ~diff[WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dsr    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            lo_r   <= '0;
            hi_r   <= '0;
        end else if (state != IDLE && bus.cancel) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        q_neg  <= sgn_a ^ sgn_b;
                        r_neg  <= sgn_a;
                        quo    <= abs_a;
                        dsr    <= abs_b;
                        rem    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        if (bus.divisor == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            dz_r   <= 1'b1;
                            lo_r   <= '1;
                            hi_r   <= bus.dividend;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // quo doubles as the dividend shifter: MSBs leave, quotient bits enter.
                    rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    lo_r   <= q_neg ? -quo : quo;
                    hi_r   <= r_neg ? -rem : rem;
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    dz_r   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A flush landing in the DONE cycle must still kill the HiLo write.
    assign pulse        = done_r & ~bus.cancel;
    assign bus.busy     = busy_r;
    assign bus.done     = pulse;
    assign bus.wlo      = pulse;
    assign bus.whi      = pulse;
    assign bus.div_zero = dz_r & ~bus.cancel;
    assign bus.wLoData  = lo_r;
    assign bus.wHiData  = hi_r;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed test-plan cases plus randomized
// operations checked against a plain-arithmetic reference.
module tb_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    div_unit_if #(.WIDTH(W)) dif();

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MIPS semantics from plain 64-bit arithmetic: truncating division,
    // remainder takes the dividend's sign, results wrap to W bits.
    task automatic ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            sa = sg ? longint'($signed(a)) : longint'(a);
            sb = sg ? longint'($signed(b)) : longint'(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end
    endtask

    // kind: 0 plain, 1 extra start at cycle inj, 2 cancel at cycle inj.
    task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int kind, input int inj,
                          output logic [W-1:0] lo, output logic [W-1:0] hi);
        logic [W-1:0] eq, er;
        logic         edz, dz;
        int           exp_lat, first, ndone, bhi;
        logic         bad_busy, bad_we, bad_dz;
        ref_div(sg, a, b, eq, er, edz);
        exp_lat  = (b == '0) ? 1 : 34;
        bhi      = (kind == 2) ? inj : exp_lat;
        first    = 0;
        ndone    = 0;
        lo       = '0;
        hi       = '0;
        dz       = 1'b0;
        bad_busy = 1'b0;
        bad_we   = 1'b0;
        bad_dz   = 1'b0;
        dif.start      = 1'b1;
        dif.signed_div = sg;
        dif.dividend   = a;
        dif.divisor    = b;
        tick();
        dif.start      = 1'b0;
        dif.signed_div = ~sg;
        dif.dividend   = $urandom;
        dif.divisor    = $urandom;
        for (int c = 1; c <= 40; c++) begin
            dif.cancel = (kind == 2 && c == inj);
            if (kind == 1 && c == inj) begin
                dif.start      = 1'b1;
                dif.signed_div = 1'b0;
                dif.dividend   = 50;
                dif.divisor    = 5;
            end else begin
                dif.start = 1'b0;
            end
            #1;
            if (dif.done === 1'b1) begin
                ndone++;
                if (first == 0) begin
                    first = c;
                    lo    = dif.wLoData;
                    hi    = dif.wHiData;
                    dz    = dif.div_zero;
                end
            end
            if (dif.wlo !== dif.done || dif.whi !== dif.done) bad_we = 1'b1;
            if (dif.div_zero === 1'b1 && dif.done !== 1'b1) bad_dz = 1'b1;
            if (dif.busy !== (c <= bhi)) bad_busy = 1'b1;
            tick();
        end
        dif.cancel = 1'b0;
        dif.start  = 1'b0;
        chk("busy_window", bad_busy, 0);
        chk("we_eq_done", bad_we, 0);
        chk("dz_only_with_done", bad_dz, 0);
        if (kind == 2) begin
            chk("cancel_no_pulse", ndone, 0);
        end else begin
            chk("done_count", ndone, 1);
            chk("latency", first, exp_lat);
            chk("lo", lo, eq);
            chk("hi", hi, er);
            chk("div_zero", dz, edz);
        end
    endtask

    initial begin
        logic [W-1:0] lo, hi, a, b;
        logic         sg;
        int           n;

        dif.start      = 1'b0;
        dif.signed_div = 1'b0;
        dif.dividend   = '0;
        dif.divisor    = '0;
        dif.cancel     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", dif.busy, 0);
        chk("rst_done", dif.done, 0);
        chk("rst_wlo", dif.wlo, 0);
        chk("rst_whi", dif.whi, 0);
        chk("rst_dz", dif.div_zero, 0);
        chk("rst_lo", dif.wLoData, 0);
        chk("rst_hi", dif.wHiData, 0);
        rst = 1'b1;
        tick();

        run_op(1'b0, 100, 7, 0, 0, lo, hi);
        chk("divu_100_7_lo", lo, 14);
        chk("divu_100_7_hi", hi, 2);
        run_op(1'b1, -32'sd7, 2, 0, 0, lo, hi);
        chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        run_op(1'b1, 7, -32'sd2, 0, 0, lo, hi);
        chk("div_7_m2_lo", lo, 32'hFFFF_FFFD);
        chk("div_7_m2_hi", hi, 1);
        run_op(1'b0, 32'hFFFF_FFFF, 2, 0, 0, lo, hi);
        chk("divu_ffff_2_lo", lo, 32'h7FFF_FFFF);
        chk("divu_ffff_2_hi", hi, 1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lo, hi);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 0);
        run_op(1'b0, 5, 0, 0, 0, lo, hi);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_hi", hi, 5);

        run_op(1'b0, 100, 7, 2, 10, lo, hi);
        run_op(1'b0, 9, 3, 0, 0, lo, hi);
        chk("after_cancel_lo", lo, 3);
        chk("after_cancel_hi", hi, 0);
        run_op(1'b0, 100, 7, 2, 34, lo, hi);
        run_op(1'b0, 100, 7, 1, 5, lo, hi);
        chk("start_busy_lo", lo, 14);
        chk("start_busy_hi", hi, 2);

        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom);
            a  = $urandom;
            case ($urandom % 8)
                0:       b = '0;
                1:       b = $urandom % 16;
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom >> ($urandom % 32);
            endcase
            run_op(sg, a, b, 0, 0, lo, hi);
        end

        // Ensure result registers hold something non-zero before the reset check.
        run_op(1'b0, 100, 7, 0, 0, lo, hi);
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.dividend   = 100;
        dif.divisor    = 7;
        tick();
        dif.start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", dif.busy, 0);
        chk("midrst_done", dif.done, 0);
        chk("midrst_lo", dif.wLoData, 0);
        chk("midrst_hi", dif.wHiData, 0);
        #2 rst = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dif.done === 1'b1) n++;
            tick();
        end
        chk("midrst_no_pulse", n, 0);
        run_op(1'b0, 9, 4, 0, 0, lo, hi);
        chk("post_rst_lo", lo, 2);
        chk("post_rst_hi", hi, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
